// File: rtl/gpi_debounce.sv
// rtl/gpi_debounce.sv - GPI synchroniser + per-bit debounce with rise/fall pulses; sticky IRQ built only when GPI_DEBOUNCE_IRQ_EN is defined
module gpi_debounce #(
   parameter int Width          = 8,
   parameter int SyncStages     = 2,
   parameter int DebounceCycles = 4
) (
   input  logic             clk_sys_i,
   input  logic             rst_sys_i,
   input  logic [Width-1:0] gp_raw_i,
   output logic [Width-1:0] gp_o,
   output logic [Width-1:0] rise_o,
   output logic [Width-1:0] fall_o,
   output logic             irq_o,
   input  logic             irq_clr_i
);

   localparam int CntW = $clog2(DebounceCycles + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

   logic [SyncStages-1:0][Width-1:0] sync_q;
   logic [Width-1:0]                 sync_w;
   logic [Width-1:0][CntW-1:0]       cnt_q;
   logic [Width-1:0]                 gp_q;
   logic [Width-1:0]                 rise_q;
   logic [Width-1:0]                 fall_q;

   assign sync_w = sync_q[SyncStages-1];

   // Synchroniser chain: stage 0 captures the asynchronous pins, last stage feeds the filter.
   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= gp_raw_i;
         for (int s = 1; s < SyncStages; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   // Per-bit filter: count consecutive mismatches, accept the new level on the last one and pulse its direction.
   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         cnt_q  <= '0;
         gp_q   <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         for (int i = 0; i < Width; i++) begin
            rise_q[i] <= 1'b0;
            fall_q[i] <= 1'b0;
            if (sync_w[i] == gp_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CntLast) begin
               cnt_q[i]  <= '0;
               gp_q[i]   <= sync_w[i];
               rise_q[i] <= sync_w[i];
               fall_q[i] <= ~sync_w[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + CntW'(1);
            end
         end
      end
   end

   assign gp_o   = gp_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

`ifdef GPI_DEBOUNCE_IRQ_EN
   logic irq_q;

   // Sticky interrupt: any pulse sets it, clear only takes effect when no pulse is present.
   always_ff @(posedge clk_sys_i) begin
      if (rst_sys_i) begin
         irq_q <= 1'b0;
      end else if ((|rise_q) || (|fall_q)) begin
         irq_q <= 1'b1;
      end else if (irq_clr_i) begin
         irq_q <= 1'b0;
      end
   end

   assign irq_o = irq_q;
`else
   logic unused_irq_clr;

   assign unused_irq_clr = irq_clr_i;
   assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_gpi_debounce.sv
// tb/tb_gpi_debounce.sv - table vectors, corner sequences and random run against a sliding-window model of gpi_debounce
module tb_gpi_debounce;

   localparam int W  = 8;
   localparam int SS = 2;
   localparam int DC = 4;
`ifdef GPI_DEBOUNCE_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] gp_raw;
   logic [W-1:0] gp;
   logic [W-1:0] rise;
   logic [W-1:0] fall;
   logic         irq;
   logic         irq_clr;

   int n_vec = 0;
   int n_bad = 0;

   gpi_debounce #(.Width(W), .SyncStages(SS), .DebounceCycles(DC)) dut (
      .clk_sys_i (clk),
      .rst_sys_i (rst),
      .gp_raw_i  (gp_raw),
      .gp_o      (gp),
      .rise_o    (rise),
      .fall_o    (fall),
      .irq_o     (irq),
      .irq_clr_i (irq_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         rst;
      logic [W-1:0] raw;
      logic         clr;
      logic [W-1:0] gp;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic         irq;
   } vec_t;

   vec_t tbl[$];

   // Reference model: a level flips when the last DC synchronised samples all disagree with it.
   logic [W-1:0] hist[$];
   logic [W-1:0] m_gp, m_rise, m_fall;
   logic         m_irq;

   task automatic model_step(input logic r, input logic [W-1:0] raw, input logic clr);
      logic [W-1:0] nr, nf;
      logic         all_diff;
      if (r) begin
         hist = {};
         for (int k = 0; k < SS + DC - 1; k++) hist.push_back('0);
         m_gp = '0; m_rise = '0; m_fall = '0; m_irq = 1'b0;
      end else begin
         if (IRQ_ON) m_irq = ((m_rise | m_fall) != '0) ? 1'b1 : (clr ? 1'b0 : m_irq);
         nr = '0; nf = '0;
         for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int j = SS - 1; j <= SS + DC - 2; j++)
               if (hist[j][b] == m_gp[b]) all_diff = 1'b0;
            if (all_diff) begin
               nr[b] = ~m_gp[b];
               nf[b] = m_gp[b];
               m_gp[b] = ~m_gp[b];
            end
         end
         m_rise = nr; m_fall = nf;
         hist.push_front(raw);
         while (hist.size() > SS + DC - 1) void'(hist.pop_back());
      end
   endtask

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input logic r, input logic [W-1:0] raw, input logic clr);
      rst = r; gp_raw = raw; irq_clr = clr;
      @(posedge clk);
      model_step(r, raw, clr);
      @(negedge clk);
   endtask

   task automatic cmp_model(input string tag);
      check({tag, ".gp"},   gp,   m_gp);
      check({tag, ".rise"}, rise, m_rise);
      check({tag, ".fall"}, fall, m_fall);
      check({tag, ".irq"},  {7'd0, irq}, {7'd0, m_irq});
   endtask

   task automatic add(input logic r, input logic [W-1:0] raw, input logic [W-1:0] g,
                      input logic [W-1:0] ri, input logic [W-1:0] fa, input logic iq);
      tbl.push_back('{rst: r, raw: raw, clr: 1'b0, gp: g, rise: ri, fall: fa, irq: iq});
   endtask

   logic [W-1:0] raw_r;
   logic         rst_r, clr_r;

   initial begin
      rst = 1'b1; gp_raw = '0; irq_clr = 1'b0;

      // Power-up with pins high, then a clean 0->1->0 on bit 0.
      for (int k = 0; k < 3; k++) add(1, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
      for (int k = 0; k < 5; k++) add(0, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
      add(0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 0);
      add(0, 8'hFF, 8'hFF, 8'h00, 8'h00, IRQ_ON);
      add(1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
      for (int k = 0; k < 5; k++) add(0, 8'h01, 8'h00, 8'h00, 8'h00, 0);
      add(0, 8'h01, 8'h01, 8'h01, 8'h00, 0);
      add(0, 8'h01, 8'h01, 8'h00, 8'h00, IRQ_ON);
      for (int k = 0; k < 5; k++) add(0, 8'h00, 8'h01, 8'h00, 8'h00, IRQ_ON);
      add(0, 8'h00, 8'h00, 8'h00, 8'h01, IRQ_ON);
      add(0, 8'h00, 8'h00, 8'h00, 8'h00, IRQ_ON);

      @(negedge clk);
      foreach (tbl[v]) begin
         tick(tbl[v].rst, tbl[v].raw, tbl[v].clr);
         check($sformatf("tbl%0d.gp", v),   gp,   tbl[v].gp);
         check($sformatf("tbl%0d.rise", v), rise, tbl[v].rise);
         check($sformatf("tbl%0d.fall", v), fall, tbl[v].fall);
         check($sformatf("tbl%0d.irq", v),  {7'd0, irq}, {7'd0, tbl[v].irq});
      end

      // Short glitch on bit 1 is rejected.
      tick(1, 8'h00, 0);
      for (int n = 1; n <= 11; n++) begin
         tick(0, (n <= 3) ? 8'h02 : 8'h00, 0);
         check("glitch.gp", gp, 8'h00);
         check("glitch.rise", rise, 8'h00);
         cmp_model("glitch");
      end

      // Bounce 1,0,1,0 then final 1 held: one rise, 6 cycles after the last transition.
      for (int n = 0; n < 4; n++) tick(0, (n % 2 == 0) ? 8'h02 : 8'h00, 0);
      for (int n = 1; n <= 8; n++) begin
         tick(0, 8'h02, 0);
         check("bounce.rise", rise, (n == 6) ? 8'h02 : 8'h00);
         check("bounce.gp", gp, (n >= 6) ? 8'h02 : 8'h00);
      end

      // Bits 2 and 5 together, then sticky IRQ behaviour.
      tick(1, 8'h00, 0);
      for (int n = 1; n <= 8; n++) begin
         tick(0, 8'h24, 0);
         check("multi.gp", gp, (n >= 6) ? 8'h24 : 8'h00);
         check("multi.rise", rise, (n == 6) ? 8'h24 : 8'h00);
         if (n >= 7) check("irq.set", {7'd0, irq}, {7'd0, IRQ_ON});
      end
      for (int n = 1; n <= 6; n++) tick(0, 8'h25, 0);
      check("irq.edge.rise", rise, 8'h01);
      tick(0, 8'h25, 1);
      check("irq.clr_with_edge", {7'd0, irq}, {7'd0, IRQ_ON});
      tick(0, 8'h25, 1);
      check("irq.clr_alone", {7'd0, irq}, 8'h00);
      tick(0, 8'h25, 0);
      check("irq.stays_clear", {7'd0, irq}, 8'h00);
      cmp_model("irq");

      // Reset in the middle of a pending count on bit 3.
      tick(1, 8'h00, 0);
      for (int n = 0; n < 4; n++) tick(0, 8'h08, 0);
      tick(1, 8'h08, 0);
      check("rstmid.gp", gp, 8'h00);
      for (int n = 1; n <= 7; n++) begin
         tick(0, 8'h08, 0);
         check("rstmid.rise", rise, (n == 6) ? 8'h08 : 8'h00);
         check("rstmid.gp", gp, (n >= 6) ? 8'h08 : 8'h00);
      end

      // Random pins, clears and occasional resets against the model.
      raw_r = $urandom();
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < W; b++)
            if ($urandom_range(0, 5) == 0) raw_r[b] = ~raw_r[b];
         rst_r = ($urandom_range(0, 199) == 0);
         clr_r = ($urandom_range(0, 7) == 0);
         tick(rst_r, raw_r, clr_r);
         cmp_model("rand");
         check("rand.excl", rise & fall, 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
